// File: rtl/frame_swap_controller.sv
// Frame-level scheduler for the LED matrix double buffer: decides when the write
// and read banks exchange roles and paces the reader restart after each swap.
module frame_swap_controller #(
    parameter int unsigned SWAP_PULSE_CYCLES = 4,
    parameter int unsigned SETTLE_CYCLES     = 2,
    parameter int unsigned CNT_WIDTH         = 8
) (
    input  logic                 I_clk,
    input  logic                 I_rst,
    input  logic                 I_enable,
    input  logic                 I_write_frame_done,
    input  logic                 I_read_frame_done,
    output logic                 O_write_ready,
    output logic                 O_swap_trigger,
    output logic                 O_write_bank,
    output logic                 O_data_valid,
    output logic                 O_read_start,
    output logic [1:0]           O_state,
    output logic [CNT_WIDTH-1:0] O_dropped_frames,
    output logic [CNT_WIDTH-1:0] O_repeated_frames
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PENDING = 2'd1,
        ST_SWAP    = 2'd2,
        ST_SETTLE  = 2'd3
    } state_t;

    localparam int unsigned TMAX = (SWAP_PULSE_CYCLES > SETTLE_CYCLES) ? SWAP_PULSE_CYCLES : SETTLE_CYCLES;
    localparam int unsigned TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam logic [TW-1:0] PULSE_LOAD  = TW'(SWAP_PULSE_CYCLES - 1);
    localparam logic [TW-1:0] SETTLE_LOAD = TW'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);

    state_t                 state, state_d;
    logic [TW-1:0]          timer, timer_d;
    logic                   ready_d, trigger_d, bank_d, valid_d, read_start_d;
    logic [CNT_WIDTH-1:0]   dropped_d, repeated_d;
    logic                   accept;

    assign O_state = state;

    always_comb begin
        state_d      = state;
        timer_d      = timer;
        bank_d       = O_write_bank;
        valid_d      = O_data_valid;
        read_start_d = 1'b0;
        dropped_d    = O_dropped_frames;
        repeated_d   = O_repeated_frames;
        accept       = I_write_frame_done && O_write_ready;

        if (I_write_frame_done && !O_write_ready && (O_dropped_frames != '1))
            dropped_d = O_dropped_frames + 1'b1;

        case (state)
            ST_IDLE: begin
                if (accept) begin
                    // Reader idle (no frame yet) or boundary right now: swap without waiting.
                    if (!O_data_valid || I_read_frame_done)
                        state_d = ST_SWAP;
                    else
                        state_d = ST_PENDING;
                end else if (I_read_frame_done) begin
                    read_start_d = 1'b1;
                    if (O_repeated_frames != '1)
                        repeated_d = O_repeated_frames + 1'b1;
                end
            end
            ST_PENDING: begin
                if (I_read_frame_done)
                    state_d = ST_SWAP;
            end
            ST_SWAP: begin
                if (timer == '0) begin
                    if (SETTLE_CYCLES == 0) begin
                        state_d      = ST_IDLE;
                        read_start_d = 1'b1;
                    end else begin
                        state_d = ST_SETTLE;
                        timer_d = SETTLE_LOAD;
                    end
                end else begin
                    timer_d = timer - 1'b1;
                end
            end
            ST_SETTLE: begin
                if (timer == '0) begin
                    state_d      = ST_IDLE;
                    read_start_d = 1'b1;
                end else begin
                    timer_d = timer - 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Bank flip, valid flag and pulse timer are all tied to SWAP entry only.
        if ((state_d == ST_SWAP) && (state != ST_SWAP)) begin
            bank_d  = ~O_write_bank;
            valid_d = 1'b1;
            timer_d = PULSE_LOAD;
        end

        trigger_d = (state_d == ST_SWAP);
        ready_d   = (state_d == ST_IDLE) && I_enable;
    end

    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            state             <= ST_IDLE;
            timer             <= '0;
            O_write_ready     <= 1'b0;
            O_swap_trigger    <= 1'b0;
            O_write_bank      <= 1'b0;
            O_data_valid      <= 1'b0;
            O_read_start      <= 1'b0;
            O_dropped_frames  <= '0;
            O_repeated_frames <= '0;
        end else begin
            state             <= state_d;
            timer             <= timer_d;
            O_write_ready     <= ready_d;
            O_swap_trigger    <= trigger_d;
            O_write_bank      <= bank_d;
            O_data_valid      <= valid_d;
            O_read_start      <= read_start_d;
            O_dropped_frames  <= dropped_d;
            O_repeated_frames <= repeated_d;
        end
    end

endmodule
